ipctrl: RTL
===========

# ipctrl

Per-direction input controller of the mesh router: accepts 64-bit packets from one link (or the local PE) into two one-entry virtual-channel buffers, computes the XY route of the buffered packet, and presents it with a one-hot output request to the five output controllers (`opctrl`). Sits directly upstream of `opctrl`: its `data_out` drives one of `opctrl`'s `data_in_*` inputs, and that controller's matching `clear_*` returns here as `clear`. Five instances per router, one per input direction (PE, S, N, E, W).

## Interface
- `DATA_W`, 64: packet width; only 64 is supported.
- `HOP_W`, 4: width of each hop-count field.

- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `polarity`  in  1  router phase bit, toggles every cycle. VC[polarity] is the internal (request) side; VC[~polarity] is the link (write) side.
- `send_in`  in  1  upstream valid.
- `data_in`  in  64  upstream packet.
- `ready_in`  out  1  = ~full[~polarity], combinational.
- `clear`  in  1  output controller consumed VC[polarity].
- `req`  out  5  one-hot output request: bit0 PE, bit1 S, bit2 N, bit3 E, bit4 W (same order as `opctrl` grant).
- `data_out`  out  64  VC[polarity] packet with its hop field updated.

## Operation
- Header format: [63] vc tag (stored, not checked); [62] x-dir (0 = E, 1 = W); [61] y-dir (0 = N, 1 = S); [60:56] reserved, passed through; [55:52] x hops; [51:48] y hops; [47:0] payload.
- Each VC has two states, EMPTY and FULL, held in a `full` flag plus a 64-bit data register.
- Write: if `send_in && ready_in`, then at the edge VC[~polarity] <= `data_in` and goes to FULL. If `send_in` arrives while `ready_in` = 0, the packet is ignored and nothing changes. The upstream side is responsible for holding the packet.
- Route of VC[polarity], XY order:
  - x hops != 0: request E or W per x-dir, and decrement x hops in `data_out`.
  - else if y hops != 0: request N or S per y-dir, and decrement y hops.
  - else: request PE, and `data_out` is unmodified.
- `req` = route one-hot when full[polarity], otherwise 5'b00000. `data_out` is the combinational function of the VC[polarity] register, and is valid whether or not `req` is asserted.
- Clear: `clear` high in a cycle clears full[polarity] at the edge. `clear` while VC[polarity] is EMPTY has no effect. The data register is not zeroed on clear.
- Write and clear in the same cycle touch different VCs by construction, so both take effect independently.
- A FULL VC that is not cleared stays FULL across polarity flips. It re-requests on every internal phase, and holds `ready_in` low on every link phase.

## Timing
- Reset (asynchronous, reset low): both VCs EMPTY, both data registers = 0. This gives `req` = 0, `data_out` = 0, `ready_in` = 1.
- Write-to-request latency is one cycle. A packet written at the edge ending a polarity=q cycle requests in the following cycle, where polarity = ~q.
- Clear-to-free latency is one edge. The freed VC becomes writable on its next link phase, one cycle later.
- Sustained throughput is one packet per cycle, alternating VCs, provided every request is cleared in its first internal phase.
- Reset asserted mid-operation drops both buffered packets immediately and forces outputs to their reset values asynchronously.

## Structure
- Shared package `noc_pkg` holds:
  - `DATA_W`, `HOP_W`
  - header field positions (VC_BIT, XDIR_BIT, YDIR_BIT, XHOP_MSB/LSB, YHOP_MSB/LSB)
  - port indices PORT_PE=0, PORT_S=1, PORT_N=2, PORT_E=3, PORT_W=4
- Sub-module `vc_buf`: one-entry buffer with write, clear, `full` and data, instantiated twice.
- Route and hop-decrement logic stays in `ipctrl`.

## Test plan
- Reset: hold `reset` low for 2 cycles -> `ready_in` = 1, `req` = 0, `data_out` = 0. Also assert reset mid-packet -> outputs return to these values without waiting for a clock edge.
- East route: write 64'h0021_0000_0000_1234 during polarity=0 -> next cycle `req` = 5'b01000 and `data_out` = 64'h0011_0000_0000_1234. Assert `clear` in that cycle -> `req` = 0 on the following internal phase.
- South and PE routes:
  - 64'h2003_0000_0000_0055 -> `req` = 5'b00010, `data_out` = 64'h2002_0000_0000_0055.
  - 64'h0000_0000_0000_00AB -> `req` = 5'b00001, `data_out` unchanged.
- Back-pressure: write into both VCs and never assert `clear` -> `ready_in` = 0 on both phases; a further `send_in` is dropped; the stored data still appears on `data_out` for its phase.
- Streaming: `send_in` held high with 8 distinct packets and `clear` asserted whenever `req` != 0 -> all 8 requests appear in order, one per cycle, with no loss or duplication.
- Stray clear: `clear` pulsed while VC[polarity] is EMPTY -> no state change, and the other VC's packet is unaffected.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: packet geometry, header field positions and output port order.
package noc_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned HOP_W     = 4;

    localparam int unsigned VC_BIT    = 63;
    localparam int unsigned XDIR_BIT  = 62;
    localparam int unsigned YDIR_BIT  = 61;
    localparam int unsigned XHOP_MSB  = 55;
    localparam int unsigned XHOP_LSB  = 52;
    localparam int unsigned YHOP_MSB  = 51;
    localparam int unsigned YHOP_LSB  = 48;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned PORT_PE   = 0;
    localparam int unsigned PORT_S    = 1;
    localparam int unsigned PORT_N    = 2;
    localparam int unsigned PORT_E    = 3;
    localparam int unsigned PORT_W    = 4;

    typedef enum logic {VcEmpty, VcFull} vc_state_e;

endpackage

// File: rtl/vc_buf.sv
// One-entry virtual-channel buffer. A write fills it and a clear empties it; the data register
// keeps its last contents after a clear.
module vc_buf #(
    parameter int unsigned DATA_W = noc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    output logic              full,
    output logic [DATA_W-1:0] data
);
    import noc_pkg::*;

    vc_state_e         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= VcEmpty;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Write and clear never target the same buffer in one cycle; write wins defensively.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (wr_en) begin
            state_d = VcFull;
            data_d  = wr_data;
        end else if (clr) begin
            state_d = VcEmpty;
        end
    end

    always_comb begin
        full = (state_q == VcFull);
        data = data_q;
    end

endmodule

// File: rtl/ipctrl.sv
// Router input controller: two one-entry VCs alternating between link and internal side by
// polarity, with XY routing and hop decrement of the internal-side packet.
module ipctrl #(
    parameter int unsigned DATA_W = noc_pkg::DATA_W,
    parameter int unsigned HOP_W  = noc_pkg::HOP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              send_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_in,
    input  logic              clear,
    output logic [4:0]        req,
    output logic [DATA_W-1:0] data_out
);
    import noc_pkg::*;

    logic [1:0]        wr_en;
    logic [1:0]        clr;
    logic [1:0]        full;
    logic [DATA_W-1:0] vc_data [2];

    logic [DATA_W-1:0] cur;
    logic [HOP_W-1:0]  xhop;
    logic [HOP_W-1:0]  yhop;
    logic [4:0]        route;

    assign ready_in = ~full[~polarity];

    // VC[~polarity] faces the link, VC[polarity] faces the output controllers.
    always_comb begin
        wr_en            = '0;
        clr              = '0;
        wr_en[~polarity] = send_in & ready_in;
        clr[polarity]    = clear & full[polarity];
    end

    for (genvar g = 0; g < 2; g++) begin : g_vc
        vc_buf #(
            .DATA_W (DATA_W)
        ) u_vc_buf (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[g]),
            .wr_data (data_in),
            .clr     (clr[g]),
            .full    (full[g]),
            .data    (vc_data[g])
        );
    end

    // XY order: exhaust x hops first, then y hops, then eject to the local PE.
    always_comb begin
        cur      = vc_data[polarity];
        xhop     = cur[XHOP_MSB:XHOP_LSB];
        yhop     = cur[YHOP_MSB:YHOP_LSB];
        route    = '0;
        data_out = cur;
        if (xhop != '0) begin
            route[cur[XDIR_BIT] ? PORT_W : PORT_E] = 1'b1;
            data_out[XHOP_MSB:XHOP_LSB]            = xhop - 1'b1;
        end else if (yhop != '0) begin
            route[cur[YDIR_BIT] ? PORT_S : PORT_N] = 1'b1;
            data_out[YHOP_MSB:YHOP_LSB]            = yhop - 1'b1;
        end else begin
            route[PORT_PE] = 1'b1;
        end
    end

    assign req = full[polarity] ? route : 5'b00000;

endmodule
